vec_alu_engine: RTL and testbench

Multi-op vector engine for the compute path. It runs element-wise binary or unary operations over vectors in the shared BRAM through port B: read A[i] (and B[i]), compute, write OUT[i]. It supports several opcodes, a configurable BRAM read latency, and busy/error status. It sits behind the same start/done control as the existing vector-add engine and drives the BRAM port B interface exclusively while busy.

---
 rtl/vec_alu_engine.sv | 207 ++++++++++++++++++++
 tb/tb_vec_alu_engine.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_alu_engine.sv
// vec_alu_engine: element-wise ALU over BRAM port B.
// Reads A[i] (and B[i]), computes, writes OUT[i].
module vec_alu_engine #(
   parameter int ADDR_WIDTH = 13,
   parameter int DATA_WIDTH = 32,
   parameter int LEN_WIDTH  = 23,
   parameter int RD_LATENCY = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [2:0]            op,
   input  logic [ADDR_WIDTH-1:0] addr_a,
   input  logic [ADDR_WIDTH-1:0] addr_b,
   input  logic [ADDR_WIDTH-1:0] addr_out,
   input  logic [LEN_WIDTH-1:0]  len,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic [ADDR_WIDTH-1:0] bram_addr_b,
   output logic [DATA_WIDTH-1:0] bram_din_b,
   input  logic [DATA_WIDTH-1:0] bram_dout_b,
   output logic                  bram_en_b,
   output logic                  bram_we_b
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_RD_A  = 3'd1;
   localparam logic [2:0] S_RD_B  = 3'd2;
   localparam logic [2:0] S_WAIT  = 3'd3;
   localparam logic [2:0] S_WRITE = 3'd4;
   localparam logic [2:0] S_DONE  = 3'd5;

   localparam logic [2:0] OP_ADD  = 3'd0;
   localparam logic [2:0] OP_SUB  = 3'd1;
   localparam logic [2:0] OP_MUL  = 3'd2;
   localparam logic [2:0] OP_MAX  = 3'd3;
   localparam logic [2:0] OP_MIN  = 3'd4;
   localparam logic [2:0] OP_RELU = 3'd5;

   localparam int CW = $clog2(RD_LATENCY + 3);
   localparam logic [CW-1:0] CYC_A = CW'(RD_LATENCY);
   localparam logic [CW-1:0] CYC_B = CW'(RD_LATENCY + 1);

   logic [2:0]            state;
   logic [2:0]            state_d;
   logic [2:0]            op_q;
   logic [ADDR_WIDTH-1:0] base_a;
   logic [ADDR_WIDTH-1:0] base_b;
   logic [ADDR_WIDTH-1:0] base_o;
   logic [LEN_WIDTH-1:0]  len_q;
   logic [LEN_WIDTH-1:0]  idx;
   logic [CW-1:0]         cyc;
   logic [DATA_WIDTH-1:0] a_q;
   logic [DATA_WIDTH-1:0] b_q;
   logic [DATA_WIDTH-1:0] res;
   logic                  err_q;

   logic                  illegal;
   logic                  is_relu;
   logic                  accept;
   logic                  cap_a;
   logic                  cap_b;
   logic                  last_cap;
   logic                  last_elem;
   logic [ADDR_WIDTH-1:0] idx_a;

   assign illegal   = op[2] & op[1];
   assign is_relu   = (op_q == OP_RELU);
   assign accept    = (state == S_IDLE) && start && !illegal;
   assign idx_a     = ADDR_WIDTH'(idx);
   assign last_elem = (idx == len_q - LEN_WIDTH'(1));
   // Cycle offsets are counted from the A address cycle (cyc == 0).
   assign cap_a     = ((state == S_RD_B) || (state == S_WAIT))
                      && (cyc == CYC_A);
   assign cap_b     = (state == S_WAIT) && (cyc == CYC_B);
   assign last_cap  = (state == S_WAIT)
                      && (cyc == (is_relu ? CYC_A : CYC_B));

   // Next-state selection for the element sequencer.
   always_comb begin
      state_d = state;
      unique case (state)
         S_IDLE: begin
            if (accept) begin
               state_d = (len == '0) ? S_DONE : S_RD_A;
            end
         end
         S_RD_A:  state_d = is_relu ? S_WAIT : S_RD_B;
         S_RD_B:  state_d = S_WAIT;
         S_WAIT:  state_d = last_cap ? S_WRITE : S_WAIT;
         S_WRITE: state_d = last_elem ? S_DONE : S_RD_A;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Element result from the captured operands.
   always_comb begin
      res = '0;
      unique case (op_q)
         OP_ADD:  res = a_q + b_q;
         OP_SUB:  res = a_q - b_q;
         OP_MUL:  res = a_q * b_q;
         OP_MAX:  res = ($signed(a_q) > $signed(b_q)) ? a_q : b_q;
         OP_MIN:  res = ($signed(a_q) < $signed(b_q)) ? a_q : b_q;
         OP_RELU: res = a_q[DATA_WIDTH-1] ? '0 : a_q;
         default: res = '0;
      endcase
   end

   // Port B drive and status, decoded from the current state.
   always_comb begin
      bram_en_b   = 1'b0;
      bram_we_b   = 1'b0;
      bram_addr_b = '0;
      bram_din_b  = '0;
      unique case (state)
         S_RD_A: begin
            bram_en_b   = 1'b1;
            bram_addr_b = base_a + idx_a;
         end
         S_RD_B: begin
            bram_en_b   = 1'b1;
            bram_addr_b = base_b + idx_a;
         end
         S_WRITE: begin
            bram_en_b   = 1'b1;
            bram_we_b   = 1'b1;
            bram_addr_b = base_o + idx_a;
            bram_din_b  = res;
         end
         default: begin
            bram_en_b = 1'b0;
         end
      endcase
   end

   assign busy = (state == S_RD_A) || (state == S_RD_B)
                 || (state == S_WAIT) || (state == S_WRITE);
   assign done = (state == S_DONE);
   assign err  = err_q;

   // State register and illegal-op pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         err_q <= 1'b0;
      end else begin
         state <= state_d;
         err_q <= (state == S_IDLE) && start && illegal;
      end
   end

   // Job parameters latched on an accepted start.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q   <= '0;
         base_a <= '0;
         base_b <= '0;
         base_o <= '0;
         len_q  <= '0;
      end else if (accept) begin
         op_q   <= op;
         base_a <= addr_a;
         base_b <= addr_b;
         base_o <= addr_out;
         len_q  <= len;
      end
   end

   // Element index and read-latency counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx <= '0;
         cyc <= '0;
      end else begin
         if (accept) begin
            idx <= '0;
         end else if ((state == S_WRITE) && !last_elem) begin
            idx <= idx + LEN_WIDTH'(1);
         end
         if ((state == S_RD_A) || (state == S_RD_B)
             || (state == S_WAIT)) begin
            cyc <= cyc + CW'(1);
         end else begin
            cyc <= '0;
         end
      end
   end

   // Operand capture as read data becomes valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q <= '0;
         b_q <= '0;
      end else begin
         if (cap_a) begin
            a_q <= bram_dout_b;
         end
         if (cap_b) begin
            b_q <= bram_dout_b;
         end
      end
   end

endmodule

// File: tb/tb_vec_alu_engine.sv
// tb_vec_alu_engine: randomized + directed bench with a
// write scoreboard and a BRAM model with read latency.
module tb_vec_alu_engine;

   localparam int AW = 13;
   localparam int DW = 32;
   localparam int LW = 23;
   localparam int L  = 2;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic [2:0]    op;
   logic [AW-1:0] addr_a;
   logic [AW-1:0] addr_b;
   logic [AW-1:0] addr_out;
   logic [LW-1:0] len;
   logic          busy;
   logic          done;
   logic          err;
   logic [AW-1:0] bram_addr_b;
   logic [DW-1:0] bram_din_b;
   logic [DW-1:0] bram_dout_b;
   logic          bram_en_b;
   logic          bram_we_b;

   vec_alu_engine #(
      .ADDR_WIDTH(AW),
      .DATA_WIDTH(DW),
      .LEN_WIDTH(LW),
      .RD_LATENCY(L)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .start(start),
      .op(op),
      .addr_a(addr_a),
      .addr_b(addr_b),
      .addr_out(addr_out),
      .len(len),
      .busy(busy),
      .done(done),
      .err(err),
      .bram_addr_b(bram_addr_b),
      .bram_din_b(bram_din_b),
      .bram_dout_b(bram_dout_b),
      .bram_en_b(bram_en_b),
      .bram_we_b(bram_we_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // BRAM model: L-stage read pipeline, garbage when not reading.
   logic [DW-1:0] mem [0:(1<<AW)-1];
   logic [DW-1:0] pipe [0:L-1];
   logic          tb_wr;
   logic [AW-1:0] tb_waddr;
   logic [DW-1:0] tb_wdata;

   always @(posedge clk) begin
      if (tb_wr) mem[tb_waddr] <= tb_wdata;
      else if (bram_en_b && bram_we_b) mem[bram_addr_b] <= bram_din_b;
      if (bram_en_b && !bram_we_b) pipe[0] <= mem[bram_addr_b];
      else pipe[0] <= 32'hDEAD_BEEF;
      for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
   end
   assign bram_dout_b = pipe[L-1];

   typedef struct packed {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } wr_t;

   wr_t exp_q[$];
   int  n_chk;
   int  n_fail;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference arithmetic from the operation definitions.
   function automatic logic [DW-1:0] ref_op(input int o,
      input logic [DW-1:0] a, input logic [DW-1:0] b);
      int sa;
      int sb;
      logic [63:0] p;
      sa = $signed(a);
      sb = $signed(b);
      p  = {32'b0, a} * {32'b0, b};
      case (o)
         0: return a + b;
         1: return a - b;
         2: return p[31:0];
         3: return (sa > sb) ? a : b;
         4: return (sa < sb) ? a : b;
         5: return (sa < 0) ? 32'd0 : a;
         default: return 32'd0;
      endcase
   endfunction

   // Monitor: every DUT write is popped against the scoreboard.
   always @(negedge clk) begin
      if (bram_en_b && bram_we_b) begin
         if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_write: addr %0h data %0h, none expected",
                     bram_addr_b, bram_din_b);
         end else begin
            wr_t w;
            w = exp_q.pop_front();
            chk("wr_addr", {51'b0, bram_addr_b}, {51'b0, w.a});
            chk("wr_data", {32'b0, bram_din_b}, {32'b0, w.d});
         end
      end
   end

   task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
      @(negedge clk);
      tb_wr    = 1'b1;
      tb_waddr = a;
      tb_wdata = d;
      @(negedge clk);
      tb_wr    = 1'b0;
   endtask

   task automatic push_exp(input int o, input logic [AW-1:0] ba,
      input logic [AW-1:0] bb, input logic [AW-1:0] bo, input int n);
      for (int i = 0; i < n; i++) begin
         logic [AW-1:0] pa;
         logic [AW-1:0] pb;
         logic [AW-1:0] po;
         wr_t w;
         pa  = ba + AW'(i);
         pb  = bb + AW'(i);
         po  = bo + AW'(i);
         w.a = po;
         w.d = ref_op(o, mem[pa], mem[pb]);
         exp_q.push_back(w);
      end
   endtask

   task automatic issue(input logic [2:0] o, input logic [AW-1:0] ba,
      input logic [AW-1:0] bb, input logic [AW-1:0] bo, input int n);
      @(negedge clk);
      start    = 1'b1;
      op       = o;
      addr_a   = ba;
      addr_b   = bb;
      addr_out = bo;
      len      = LW'(n);
      @(posedge clk);
      #1;
      start    = 1'b0;
      op       = 3'($urandom);
      addr_a   = AW'($urandom);
      addr_b   = AW'($urandom);
      addr_out = AW'($urandom);
      len      = LW'($urandom);
   endtask

   task automatic run_job(input logic [2:0] o, input logic [AW-1:0] ba,
      input logic [AW-1:0] bb, input logic [AW-1:0] bo, input int n,
      input bit midstart, output int dcyc, output int nbusy,
      output int nrd, output int ndone);
      push_exp(int'(o), ba, bb, bo, n);
      issue(o, ba, bb, bo, n);
      dcyc  = -1;
      nbusy = 0;
      nrd   = 0;
      ndone = 0;
      for (int k = 1; k <= 300; k++) begin
         @(negedge clk);
         if (busy) nbusy++;
         if (bram_en_b && !bram_we_b) nrd++;
         if (done) begin
            ndone++;
            if (dcyc < 0) dcyc = k;
         end
         if (midstart && k == 7) begin
            start = 1'b1;
            op    = 3'd0;
            len   = LW'(1);
         end else begin
            start = 1'b0;
         end
         if (dcyc >= 0 && k >= dcyc + 3) break;
      end
      if (dcyc < 0) $display("FAIL done_timeout: got no done, expected done");
      chk("sb_empty", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
   endtask

   function automatic int exp_cyc(input int o, input int n);
      return 1 + n * ((o == 5) ? (L + 2) : (L + 3));
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int dc;
      int nb;
      int nr;
      int nd;
      int cnt_err;
      int cnt_en;
      int cnt_done;
      int cnt_busy;
      logic [DW-1:0] ea [0:3];
      logic [DW-1:0] eb [0:3];
      logic [DW-1:0] eo [0:3];
      logic [DW-1:0] op_exp [1:4];

      n_chk    = 0;
      n_fail   = 0;
      rst_n    = 1'b0;
      start    = 1'b0;
      op       = '0;
      addr_a   = '0;
      addr_b   = '0;
      addr_out = '0;
      len      = '0;
      tb_wr    = 1'b0;
      tb_waddr = '0;
      tb_wdata = '0;
      repeat (3) @(negedge clk);
      chk("reset_outputs", {14'b0, busy, done, err, bram_en_b, bram_we_b,
          bram_addr_b, bram_din_b}, 64'd0);
      rst_n = 1'b1;

      // Directed ADD, len 4, including a wrapping element.
      ea[0] = 32'd1;  ea[1] = 32'd2;  ea[2] = 32'd3;  ea[3] = 32'hFFFF_FFFF;
      eb[0] = 32'd10; eb[1] = 32'd20; eb[2] = 32'd30; eb[3] = 32'd1;
      eo[0] = 32'd11; eo[1] = 32'd22; eo[2] = 32'd33; eo[3] = 32'd0;
      for (int i = 0; i < 4; i++) begin
         poke(AW'(13'h010 + i), ea[i]);
         poke(AW'(13'h020 + i), eb[i]);
      end
      run_job(3'd0, 13'h010, 13'h020, 13'h030, 4, 1'b0, dc, nb, nr, nd);
      chk("add_done_cycle", 64'(dc), 64'd21);
      chk("add_busy_cycles", 64'(nb), 64'd20);
      chk("add_reads", 64'(nr), 64'd8);
      chk("add_done_count", 64'(nd), 64'd1);
      for (int i = 0; i < 4; i++)
         chk("add_mem_out", {32'b0, mem[AW'(13'h030 + i)]}, {32'b0, eo[i]});

      // SUB/MUL/MAX/MIN on -2 and 3.
      poke(13'h100, 32'hFFFF_FFFE);
      poke(13'h200, 32'd3);
      op_exp[1] = 32'hFFFF_FFFB;
      op_exp[2] = 32'hFFFF_FFFA;
      op_exp[3] = 32'd3;
      op_exp[4] = 32'hFFFF_FFFE;
      for (int o = 1; o <= 4; o++) begin
         run_job(3'(o), 13'h100, 13'h200, AW'(13'h300 + o), 1, 1'b0,
                 dc, nb, nr, nd);
         chk("op_done_cycle", 64'(dc), 64'd6);
         chk("op_result", {32'b0, mem[AW'(13'h300 + o)]}, {32'b0, op_exp[o]});
      end

      // RELU, len 3: unary, one read per element.
      poke(13'h400, 32'd5);
      poke(13'h401, 32'h8000_0000);
      poke(13'h402, 32'd0);
      run_job(3'd5, 13'h400, 13'h500, 13'h600, 3, 1'b0, dc, nb, nr, nd);
      chk("relu_done_cycle", 64'(dc), 64'd13);
      chk("relu_reads", 64'(nr), 64'd3);
      chk("relu_out0", {32'b0, mem[13'h600]}, 64'd5);
      chk("relu_out1", {32'b0, mem[13'h601]}, 64'd0);
      chk("relu_out2", {32'b0, mem[13'h602]}, 64'd0);

      // Illegal op: one err pulse and nothing else.
      @(negedge clk);
      start = 1'b1;
      op    = 3'd7;
      len   = LW'(3);
      @(posedge clk);
      #1;
      start    = 1'b0;
      cnt_err  = 0;
      cnt_en   = 0;
      cnt_done = 0;
      cnt_busy = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (err) cnt_err++;
         if (bram_en_b || bram_we_b) cnt_en++;
         if (done) cnt_done++;
         if (busy) cnt_busy++;
      end
      chk("illegal_err_pulse", 64'(cnt_err), 64'd1);
      chk("illegal_no_bram", 64'(cnt_en), 64'd0);
      chk("illegal_no_done", 64'(cnt_done), 64'd0);
      chk("illegal_no_busy", 64'(cnt_busy), 64'd0);

      // len 0: straight to done, no BRAM access.
      run_job(3'd0, 13'h010, 13'h020, 13'h030, 0, 1'b0, dc, nb, nr, nd);
      chk("len0_done_soon", 64'(dc >= 1 && dc <= 2), 64'd1);
      chk("len0_no_reads", 64'(nr), 64'd0);
      chk("len0_done_count", 64'(nd), 64'd1);

      // Output address wrap, with a start pulse mid-run.
      for (int i = 0; i < 4; i++) begin
         poke(AW'(13'h700 + i), $urandom);
         poke(AW'(13'h800 + i), $urandom);
      end
      run_job(3'd0, 13'h700, 13'h800, 13'h1FFE, 4, 1'b1, dc, nb, nr, nd);
      chk("wrap_done_cycle", 64'(dc), 64'd21);
      chk("wrap_done_count", 64'(nd), 64'd1);
      chk("wrap_mem_0000", {32'b0, mem[13'h0000]},
          {32'b0, mem[13'h702] + mem[13'h802]});

      // Async reset during the third element's wait.
      for (int i = 0; i < 4; i++) begin
         poke(AW'(13'h900 + i), $urandom);
         poke(AW'(13'hA00 + i), $urandom);
      end
      push_exp(0, 13'h900, 13'hA00, 13'hB00, 4);
      issue(3'd0, 13'h900, 13'hA00, 13'hB00, 4);
      for (int k = 1; k <= 13; k++) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst_outputs_zero", {14'b0, busy, done, err, bram_en_b, bram_we_b,
          bram_addr_b, bram_din_b}, 64'd0);
      chk("rst_pending_writes", 64'(exp_q.size()), 64'd2);
      exp_q.delete();
      cnt_done = 0;
      cnt_busy = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (k == 3) rst_n = 1'b1;
         if (done) cnt_done++;
         if (busy) cnt_busy++;
      end
      chk("rst_no_done", 64'(cnt_done), 64'd0);
      chk("rst_idle_after", 64'(cnt_busy), 64'd0);
      run_job(3'd0, 13'h900, 13'hA00, 13'hB00, 4, 1'b0, dc, nb, nr, nd);
      chk("post_rst_done_cycle", 64'(dc), 64'd21);

      // Randomized jobs over all legal ops.
      for (int t = 0; t < 20; t++) begin
         int o;
         int n;
         logic [AW-1:0] ba;
         o  = $urandom_range(0, 5);
         n  = $urandom_range(1, 6);
         ba = AW'($urandom);
         for (int i = 0; i < n; i++) begin
            poke(ba + AW'(i), $urandom);
            poke(ba + AW'(13'h400) + AW'(i), $urandom);
         end
         run_job(3'(o), ba, ba + AW'(13'h400), ba + AW'(13'h800), n, 1'b0,
                 dc, nb, nr, nd);
         chk("rand_done_cycle", 64'(dc), 64'(exp_cyc(o, n)));
         chk("rand_done_count", 64'(nd), 64'd1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
